// File: rtl/draw_bg_pattern_pkg.sv
// Shared types and constants for the background drawing stage: pattern modes,
// border colours, timing-generator edges and the bundled VGA bus used by the delay line.
package draw_bg_pattern_pkg;

  typedef enum logic [1:0] {
    BG_SOLID    = 2'd0,
    BG_CHECKER  = 2'd1,
    BG_GRADIENT = 2'd2,
    BG_SCROLL   = 2'd3
  } bg_mode_e;

  localparam logic [11:0] COL_TOP   = 12'hff0;
  localparam logic [11:0] COL_BOT   = 12'hf00;
  localparam logic [11:0] COL_LEFT  = 12'h0f0;
  localparam logic [11:0] COL_RIGHT = 12'h00f;
  localparam logic [11:0] COL_BLANK = 12'h000;

  // Edges of the board timing generator's blanking windows (800x600 active area).
  localparam int HBLNK_STOP_BACK   = 0;
  localparam int HBLNK_START_FRONT = 799;
  localparam int VBLNK_STOP_BACK   = 0;
  localparam int VBLNK_START_FRONT = 600;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;

  localparam int VGA_BUS_W = $bits(vga_bus_t);

  function automatic logic in_range(input logic [10:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/draw_bg_pattern_vga_delay.sv
// Pure delay line for the bundled VGA bus; every field moves together so
// timing and colour stay aligned.
module vga_delay
  import draw_bg_pattern_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VGA_BUS_W-1:0] d,
  output logic [VGA_BUS_W-1:0] q
);

  logic [VGA_BUS_W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/draw_bg_pattern.sv
// Background stage: fills active pixels with a frame-synchronously configured pattern,
// draws coloured borders, blanks outside the active area, delays the bus LATENCY clocks.
module draw_bg_pattern
  import draw_bg_pattern_pkg::*;
#(
  parameter int          BORDER_W  = 1,
  parameter int          TILE_LOG2 = 4,
  parameter int          LATENCY   = 2,
  parameter logic [11:0] RST_COLOR = 12'h888
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] in_hcount,
  input  logic [10:0] in_vcount,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic        in_hblnk,
  input  logic        in_vblnk,
  input  logic [11:0] in_rgb,
  output logic [10:0] out_hcount,
  output logic [10:0] out_vcount,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        out_hblnk,
  output logic        out_vblnk,
  output logic [11:0] out_rgb,
  input  logic        cfg_valid_i,
  input  logic [1:0]  cfg_mode_i,
  input  logic [11:0] cfg_color_i,
  input  logic        border_en_i,
  output logic        frame_tick_o
);

  localparam int V_TOP = VBLNK_STOP_BACK + 1;
  localparam int V_BOT = VBLNK_START_FRONT - 1;
  localparam int H_L   = HBLNK_STOP_BACK + 2;
  localparam int H_R   = HBLNK_START_FRONT;

  logic        vblnk_prev;
  logic        boundary;
  bg_mode_e    pend_mode, act_mode;
  logic [11:0] pend_color, act_color;
  logic [9:0]  scroll_off;
  logic [10:0] h_scr;
  logic        par_chk, par_scr;
  logic [11:0] pix_rgb;
  vga_bus_t    s1, out_bus;

  assign boundary     = in_vblnk & ~vblnk_prev & ~rst;
  assign frame_tick_o = boundary;

  // A strobe landing on the boundary bypasses the pending regs so it takes effect this frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      pend_mode  <= BG_SOLID;
      pend_color <= RST_COLOR;
      act_mode   <= BG_SOLID;
      act_color  <= RST_COLOR;
      scroll_off <= '0;
    end else begin
      vblnk_prev <= in_vblnk;
      if (cfg_valid_i) begin
        pend_mode  <= bg_mode_e'(cfg_mode_i);
        pend_color <= cfg_color_i;
      end
      if (boundary) begin
        if (act_mode == BG_SCROLL) scroll_off <= scroll_off + 10'd1;
        if (cfg_valid_i) begin
          act_mode  <= bg_mode_e'(cfg_mode_i);
          act_color <= cfg_color_i;
        end else begin
          act_mode  <= pend_mode;
          act_color <= pend_color;
        end
      end
    end
  end

  always_comb begin
    h_scr   = in_hcount + {1'b0, scroll_off};
    par_chk = in_hcount[TILE_LOG2] ^ in_vcount[TILE_LOG2];
    par_scr = h_scr[TILE_LOG2] ^ in_vcount[TILE_LOG2];
    pix_rgb = act_color;
    if (in_hblnk | in_vblnk)
      pix_rgb = COL_BLANK;
    else if (border_en_i && in_range(in_vcount, V_TOP, V_TOP + BORDER_W - 1))
      pix_rgb = COL_TOP;
    else if (border_en_i && in_range(in_vcount, V_BOT - BORDER_W + 1, V_BOT))
      pix_rgb = COL_BOT;
    else if (border_en_i && in_range(in_hcount, H_L, H_L + BORDER_W - 1))
      pix_rgb = COL_LEFT;
    else if (border_en_i && in_range(in_hcount, H_R - BORDER_W + 1, H_R))
      pix_rgb = COL_RIGHT;
    else if (in_rgb != 12'h000)
      pix_rgb = in_rgb;
    else begin
      unique case (act_mode)
        BG_SOLID:    pix_rgb = act_color;
        BG_CHECKER:  pix_rgb = par_chk ? ~act_color : act_color;
        BG_GRADIENT: pix_rgb = {in_hcount[9:6], in_vcount[9:6], act_color[3:0]};
        BG_SCROLL:   pix_rgb = par_scr ? ~act_color : act_color;
        default:     pix_rgb = act_color;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.hcount <= in_hcount;
      s1.vcount <= in_vcount;
      s1.hsync  <= in_hsync;
      s1.vsync  <= in_vsync;
      s1.hblnk  <= in_hblnk;
      s1.vblnk  <= in_vblnk;
      s1.rgb    <= pix_rgb;
    end
  end

  generate
    if (LATENCY == 1) begin : g_no_delay
      assign out_bus = s1;
    end else begin : g_delay
      vga_delay #(.DEPTH(LATENCY - 1)) u_delay (
        .clk (clk),
        .rst (rst),
        .d   (s1),
        .q   (out_bus)
      );
    end
  endgenerate

  assign out_hcount = out_bus.hcount;
  assign out_vcount = out_bus.vcount;
  assign out_hsync  = out_bus.hsync;
  assign out_vsync  = out_bus.vsync;
  assign out_hblnk  = out_bus.hblnk;
  assign out_vblnk  = out_bus.vblnk;
  assign out_rgb    = out_bus.rgb;

endmodule
